// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants, types and helpers for the pipeline control unit.
//   - stage index constants STG_IF..STG_WB (bit positions in stall/flush vectors)
//   - PIPE_STATE_WIDTH and the FSM state encodings PIPE_RUN / PIPE_MEM_WAIT / PIPE_DRAIN
//   - per-case stall/flush masks and helpers that build a control bundle
package pipe_ctrl_pkg;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam int STG_NUM = 5;

   localparam int PIPE_STATE_WIDTH = 2;

   typedef enum logic [PIPE_STATE_WIDTH-1:0] {
      PIPE_RUN      = 2'd0,
      PIPE_MEM_WAIT = 2'd1,
      PIPE_DRAIN    = 2'd2
   } pipe_state_e;

   typedef logic [STG_NUM-1:0] stg_vec_t;

   localparam stg_vec_t STG_NONE    = 5'b00000;
   localparam stg_vec_t STG_ALL     = 5'b11111;
   localparam stg_vec_t TRAP_FLUSH  = 5'b01111;
   localparam stg_vec_t MEM_STALL   = 5'b01111;
   localparam stg_vec_t MEM_FLUSH   = 5'b10000;
   localparam stg_vec_t BR_FLUSH    = 5'b00011;
   localparam stg_vec_t LU_STALL    = 5'b00011;
   localparam stg_vec_t LU_FLUSH    = 5'b00100;
   localparam stg_vec_t IC_STALL    = 5'b00001;
   localparam stg_vec_t IC_FLUSH    = 5'b00010;
   localparam stg_vec_t DRAIN_STALL = 5'b00001;
   localparam stg_vec_t DRAIN_FLUSH = 5'b01110;

   typedef struct packed {
      stg_vec_t stall;
      stg_vec_t flush;
      logic     pc_hold;
   } pipe_ctl_t;

   function automatic pipe_ctl_t make_ctl(input stg_vec_t stall, input stg_vec_t flush,
                                          input logic pc_hold);
      pipe_ctl_t c;
      c.stall   = stall;
      c.flush   = flush;
      c.pc_hold = pc_hold;
      return c;
   endfunction

   // Lower-priority RUN cases (below trap and dcache); shared by RUN and
   // the MEM_WAIT release cycle.
   function automatic pipe_ctl_t run_minor(input logic branch, input logic hazard,
                                           input logic icache);
      pipe_ctl_t c;
      if (branch)      c = make_ctl(STG_NONE, BR_FLUSH, 1'b0);
      else if (hazard) c = make_ctl(LU_STALL, LU_FLUSH, 1'b1);
      else if (icache) c = make_ctl(IC_STALL, IC_FLUSH, 1'b1);
      else             c = make_ctl(STG_NONE, STG_NONE, 1'b0);
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: two saturating performance counters.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall_en, flush_en  count enable for this cycle
//   stall_cnt, flush_cnt  counter values (saturate at all ones)
module pipe_ctrl_perf #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall_en,
   input  logic                 flush_en,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (flush_en && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core. Turns hazard,
// cache-busy, branch-redirect and trap requests into per-stage stall/flush
// strobes and a PC hold. Outputs are combinational from registered state,
// drain counter and current inputs.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   DecodeHazard_StallReq           load-use stall request
//   Icache_Busy, Dcache_Busy        fetch / Mem-stage access pending
//   EX_BranchTaken, Trap_Req        redirect / trap accepted at Mem
//   PipeCtrl_Stall, PipeCtrl_Flush  per-stage hold / bubble (bit0=IF .. bit4=WB)
//   PipeCtrl_PcHold                 PC hold
//   PipeCtrl_State                  current FSM state
//   PipeCtrl_StallCnt/FlushCnt      perf counters
// Build option: define PIPE_CTRL_PERF_EN to instantiate the perf counters;
// otherwise the count ports read 0.
//
// state         | meaning
// PIPE_RUN      | normal flow, priority trap > dcache > branch > hazard > icache
// PIPE_MEM_WAIT | back end held while the Mem-stage access is pending
// PIPE_DRAIN    | front end held for DRAIN_CYCLES after a trap flush
// (encoding 3)  | unreachable, behaves as PIPE_RUN
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGE_NUM    = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        DecodeHazard_StallReq,
   input  logic                        Icache_Busy,
   input  logic                        Dcache_Busy,
   input  logic                        EX_BranchTaken,
   input  logic                        Trap_Req,
   output logic [STAGE_NUM-1:0]        PipeCtrl_Stall,
   output logic [STAGE_NUM-1:0]        PipeCtrl_Flush,
   output logic                        PipeCtrl_PcHold,
   output logic [PIPE_STATE_WIDTH-1:0] PipeCtrl_State,
   output logic [CNT_WIDTH-1:0]        PipeCtrl_StallCnt,
   output logic [CNT_WIDTH-1:0]        PipeCtrl_FlushCnt
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   pipe_state_e        state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   pipe_ctl_t          ctl_c;

   always_comb begin
      ctl_c   = make_ctl(STG_NONE, STG_NONE, 1'b0);
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         PIPE_MEM_WAIT: begin
            // Trap is not taken here even on the release cycle; its source
            // holds it and it is accepted once back in RUN.
            if (Dcache_Busy) begin
               ctl_c = make_ctl(MEM_STALL, MEM_FLUSH, 1'b1);
            end else begin
               ctl_c   = run_minor(EX_BranchTaken, DecodeHazard_StallReq, Icache_Busy);
               state_d = PIPE_RUN;
            end
         end
         PIPE_DRAIN: begin
            ctl_c = make_ctl(DRAIN_STALL, DRAIN_FLUSH, 1'b1);
            if (drain_q == '0) state_d = PIPE_RUN;
            else               drain_d = drain_q - DRAIN_W'(1);
         end
         default: begin
            state_d = PIPE_RUN;
            if (Trap_Req) begin
               ctl_c   = make_ctl(STG_NONE, TRAP_FLUSH, 1'b0);
               state_d = PIPE_DRAIN;
               drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
            end else if (Dcache_Busy) begin
               ctl_c   = make_ctl(MEM_STALL, MEM_FLUSH, 1'b1);
               state_d = PIPE_MEM_WAIT;
            end else begin
               ctl_c = run_minor(EX_BranchTaken, DecodeHazard_StallReq, Icache_Busy);
            end
         end
      endcase
      // Reset forces every pipeline register to a bubble and freezes the PC.
      if (!rst_n) ctl_c = make_ctl(STG_NONE, STG_ALL, 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PIPE_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign PipeCtrl_Stall  = ctl_c.stall;
   assign PipeCtrl_Flush  = ctl_c.flush;
   assign PipeCtrl_PcHold = ctl_c.pc_hold;
   assign PipeCtrl_State  = state_q;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_en  (|ctl_c.stall),
      .flush_en  (|ctl_c.flush),
      .stall_cnt (PipeCtrl_StallCnt),
      .flush_cnt (PipeCtrl_FlushCnt)
   );
`else
   assign PipeCtrl_StallCnt = '0;
   assign PipeCtrl_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl. Inputs change 1 time
// unit after the rising edge; outputs are checked on the falling edge.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        hazard, icache, dcache, branch, trap;
   logic [4:0]  stall, flush;
   logic        pc_hold;
   logic [1:0]  state;
   logic [31:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_sc   = 0;
   int exp_fc   = 0;

   pipe_ctrl #(
      .STAGE_NUM    (5),
      .DRAIN_CYCLES (3),
      .CNT_WIDTH    (32)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .DecodeHazard_StallReq (hazard),
      .Icache_Busy           (icache),
      .Dcache_Busy           (dcache),
      .EX_BranchTaken        (branch),
      .Trap_Req              (trap),
      .PipeCtrl_Stall        (stall),
      .PipeCtrl_Flush        (flush),
      .PipeCtrl_PcHold       (pc_hold),
      .PipeCtrl_State        (state),
      .PipeCtrl_StallCnt     (stall_cnt),
      .PipeCtrl_FlushCnt     (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // req = {trap, dcache, branch, hazard, icache}
   task automatic step(input string tag, input logic [4:0] req, input logic [4:0] es,
                       input logic [4:0] ef, input logic ep, input logic [1:0] est);
      {trap, dcache, branch, hazard, icache} = req;
      @(negedge clk);
      chk({tag, ".stall"},  32'(stall),   32'(es));
      chk({tag, ".flush"},  32'(flush),   32'(ef));
      chk({tag, ".pchold"}, 32'(pc_hold), 32'(ep));
      chk({tag, ".state"},  32'(state),   32'(est));
      if (es != 5'b0) exp_sc++;
      if (ef != 5'b0) exp_fc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
      chk({tag, ".stallcnt"}, stall_cnt, 32'(exp_sc));
      chk({tag, ".flushcnt"}, flush_cnt, 32'(exp_fc));
`else
      chk({tag, ".stallcnt"}, stall_cnt, 32'd0);
      chk({tag, ".flushcnt"}, flush_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".stall"},  32'(stall),   32'h00);
      chk({tag, ".flush"},  32'(flush),   32'h1f);
      chk({tag, ".pchold"}, 32'(pc_hold), 32'h1);
      chk({tag, ".state"},  32'(state),   32'h0);
   endtask

   localparam logic [4:0] R_NONE = 5'b00000;
   localparam logic [4:0] R_TRAP = 5'b10000;
   localparam logic [4:0] R_DC   = 5'b01000;
   localparam logic [4:0] R_BR   = 5'b00100;
   localparam logic [4:0] R_HZ   = 5'b00010;
   localparam logic [4:0] R_IC   = 5'b00001;

   initial begin
      rst_n = 1'b0;
      {trap, dcache, branch, hazard, icache} = 5'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset.stallcnt", stall_cnt, 32'd0);
      chk("reset.flushcnt", flush_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step("idle0", R_NONE, 5'b00000, 5'b00000, 1'b0, 2'd0);

      // single-cycle load-use
      step("lu",      R_HZ,   5'b00011, 5'b00100, 1'b1, 2'd0);
      step("lu_drop", R_NONE, 5'b00000, 5'b00000, 1'b0, 2'd0);
      chk_cnt("lu");

      step("icache", R_IC, 5'b00001, 5'b00010, 1'b1, 2'd0);

      // dcache busy 4 cycles
      step("dc1",  R_DC,   5'b01111, 5'b10000, 1'b1, 2'd0);
      step("dc2",  R_DC,   5'b01111, 5'b10000, 1'b1, 2'd1);
      step("dc3",  R_DC,   5'b01111, 5'b10000, 1'b1, 2'd1);
      step("dc4",  R_DC,   5'b01111, 5'b10000, 1'b1, 2'd1);
      step("dc5",  R_NONE, 5'b00000, 5'b00000, 1'b0, 2'd1);
      step("dc6",  R_NONE, 5'b00000, 5'b00000, 1'b0, 2'd0);
      chk_cnt("dc");

      // trap + branch, requests during drain are ignored
      step("trap",   R_TRAP | R_BR,  5'b00000, 5'b01111, 1'b0, 2'd0);
      step("drain1", R_TRAP | R_HZ,  5'b00001, 5'b01110, 1'b1, 2'd2);
      step("drain2", R_DC | R_BR,    5'b00001, 5'b01110, 1'b1, 2'd2);
      step("drain3", R_IC,           5'b00001, 5'b01110, 1'b1, 2'd2);
      step("post",   R_NONE,         5'b00000, 5'b00000, 1'b0, 2'd0);
      chk_cnt("trap");

      step("br_hz_ic", R_BR | R_HZ | R_IC, 5'b00000, 5'b00011, 1'b0, 2'd0);
      step("hz_ic",    R_HZ | R_IC,        5'b00011, 5'b00100, 1'b1, 2'd0);

      // trap held during MEM_WAIT is ignored, including on the release cycle
      step("mw_dc",   R_DC,               5'b01111, 5'b10000, 1'b1, 2'd0);
      step("mw_trap", R_DC | R_TRAP,      5'b01111, 5'b10000, 1'b1, 2'd1);
      step("mw_rel",  R_TRAP | R_BR,      5'b00000, 5'b00011, 1'b0, 2'd1);
      step("mw_take", R_TRAP,             5'b00000, 5'b01111, 1'b0, 2'd0);
      step("mw_d1",   R_NONE,             5'b00001, 5'b01110, 1'b1, 2'd2);
      step("mw_d2",   R_NONE,             5'b00001, 5'b01110, 1'b1, 2'd2);
      step("mw_d3",   R_NONE,             5'b00001, 5'b01110, 1'b1, 2'd2);
      step("mw_run",  R_IC,               5'b00001, 5'b00010, 1'b1, 2'd0);
      chk_cnt("mw");

      // reset mid-DRAIN
      step("rd_trap", R_TRAP, 5'b00000, 5'b01111, 1'b0, 2'd0);
      step("rd_d1",   R_NONE, 5'b00001, 5'b01110, 1'b1, 2'd2);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rd_async");
      @(negedge clk);
      chk_reset_outputs("rd_hold");
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      exp_sc = 0;
      exp_fc = 0;
      chk_cnt("rd_rel");
      step("rd_run", R_HZ, 5'b00011, 5'b00100, 1'b1, 2'd0);
      chk_cnt("rd_lu");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
